// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the skewed multi-column FIFO read controller.
//   state_t     : controller FSM encoding (IDLE / RUN / DONE)
//   MODE_*      : read pacing selection
//   sel_default : substitute a default when a run-time config field is zero
package fifo_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic MODE_PACED  = 1'b0;
   localparam logic MODE_STREAM = 1'b1;

   // A zero config field means "use the build-time default".
   function automatic logic [31:0] sel_default(input logic [31:0] val,
                                               input logic [31:0] dflt);
      return (val == 32'd0) ? dflt : val;
   endfunction

endpackage

// File: rtl/fifo_controller_skew_chan.sv
// Per-column read channel: read counter, eligibility, pacing and the
// shift-register enable latch. The parent owns the FSM and skew counter.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_run                 parent FSM is in RUN
//   i_idle                parent FSM is in IDLE (counter held at zero)
//   i_go                  parent stays in RUN next cycle (reads allowed out)
//   i_keep                parent is not returning to IDLE (sr enable held)
//   i_skew_ok             skew counter has reached this column's index
//   i_burst               latched reads-per-burst
//   i_mode                latched pacing mode
//   i_fifo_empty          source FIFO empty for this column
//   i_fifo_array_full     shift register full for this column
//   o_rd_en               registered FIFO read strobe
//   o_sr_en               registered shift-register enable
//   o_cnt_done_q          registered count has reached the burst length
//   o_cnt_done_d          count including this cycle's read reaches it
module fifo_ctrl_chan
   import fifo_ctrl_pkg::*;
#(
   parameter int CNT_W = 9
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_run,
   input  logic             i_idle,
   input  logic             i_go,
   input  logic             i_keep,
   input  logic             i_skew_ok,
   input  logic [CNT_W-1:0] i_burst,
   input  logic             i_mode,
   input  logic             i_fifo_empty,
   input  logic             i_fifo_array_full,
   output logic             o_rd_en,
   output logic             o_sr_en,
   output logic             o_cnt_done_q,
   output logic             o_cnt_done_d
);

   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic             rd_en_q, rd_en_d;
   logic             sr_en_q, sr_en_d;
   logic             eligible;

   always_comb begin
      // Paced mode leaves a gap after every strobe of this channel.
      eligible = i_run && i_skew_ok && (rd_cnt_q < i_burst)
                 && !i_fifo_empty && !i_fifo_array_full
                 && ((i_mode == MODE_STREAM) || !rd_en_q);
      rd_cnt_d = i_idle ? '0 : rd_cnt_q + {{(CNT_W-1){1'b0}}, eligible};
      rd_en_d  = eligible && i_go;
      sr_en_d  = i_keep && (sr_en_q || rd_en_d);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_cnt_q <= '0;
         rd_en_q  <= 1'b0;
         sr_en_q  <= 1'b0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         rd_en_q  <= rd_en_d;
         sr_en_q  <= sr_en_d;
      end
   end

   assign o_rd_en      = rd_en_q;
   assign o_sr_en      = sr_en_q;
   assign o_cnt_done_q = (rd_cnt_q == i_burst);
   assign o_cnt_done_d = (rd_cnt_d == i_burst);

endmodule

// File: rtl/fifo_controller_skew.sv
// Drives NCH systolic-array column feeds from per-column source FIFOs.
// Column k starts reading k cycles after column 0, giving the array skew.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_occupants           words held in the source buffer
//   i_thresh              arm threshold (0 -> NCH*ROW)
//   i_burst_len           reads per channel per burst (0 -> ROW)
//   i_mode                0 paced (1 read / 2 cycles), 1 streaming
//   i_fifo_empty          per-channel FIFO empty
//   i_fifo_array_full     per-column shift register full
//   o_fifo_read_enable    per-channel read strobes
//   o_sr_enable           per-column shift enables
//   o_busy                high in RUN and DONE
//   o_done                one-cycle burst-complete pulse
//   o_underrun            one-cycle abort pulse
//
// state | meaning
// IDLE  | waiting for occupancy >= threshold; config sampled on exit
// RUN   | channels issue staggered reads until every count hits the burst
// DONE  | one cycle, o_done high, then back to IDLE
module fifo_controller_skew
   import fifo_ctrl_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int ROW    = 9,
   parameter int W_ADDR = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [W_ADDR:0]   i_occupants,
   input  logic [W_ADDR:0]   i_thresh,
   input  logic [W_ADDR:0]   i_burst_len,
   input  logic              i_mode,
   input  logic [NCH-1:0]    i_fifo_empty,
   input  logic [NCH-1:0]    i_fifo_array_full,
   output logic [NCH-1:0]    o_fifo_read_enable,
   output logic [NCH-1:0]    o_sr_enable,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_underrun
);

   localparam int CNT_W  = W_ADDR + 1;
   localparam int SKEW_W = $clog2(NCH + 1);

   state_t            state_q, state_d;
   logic [SKEW_W-1:0] skew_q, skew_d;
   logic              mode_q, mode_d;
   logic [CNT_W-1:0]  burst_q, burst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              underrun_q, underrun_d;

   logic [CNT_W-1:0]  eff_thresh, eff_burst;
   logic [NCH-1:0]    skew_ok, cnt_done_q, cnt_done_d;
   logic              go, keep, idle, run;

   assign eff_thresh = CNT_W'(sel_default(32'(i_thresh), 32'(NCH * ROW)));
   assign eff_burst  = CNT_W'(sel_default(32'(i_burst_len), 32'(ROW)));

   always_comb begin
      skew_ok = '0;
      for (int k = 0; k < NCH; k++) begin
         skew_ok[k] = (int'(skew_q) >= k);
      end
   end

   always_comb begin
      state_d    = state_q;
      skew_d     = skew_q;
      mode_d     = mode_q;
      burst_d    = burst_q;
      done_d     = 1'b0;
      underrun_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_occupants >= eff_thresh) begin
               state_d = ST_RUN;
               mode_d  = i_mode;
               burst_d = eff_burst;
               skew_d  = '0;
            end
         end
         ST_RUN: begin
            if (skew_q != SKEW_W'(NCH)) skew_d = skew_q + 1'b1;
            // Completion wins; underrun only if this cycle's reads still
            // leave the burst short.
            if (&cnt_done_q) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else if ((i_occupants == '0) && !(&cnt_done_d)) begin
               state_d    = ST_IDLE;
               underrun_d = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   assign run  = (state_q == ST_RUN);
   assign idle = (state_q == ST_IDLE);
   assign go   = (state_d == ST_RUN);
   assign keep = (state_d != ST_IDLE);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         skew_q     <= '0;
         mode_q     <= MODE_PACED;
         burst_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         skew_q     <= skew_d;
         mode_q     <= mode_d;
         burst_q    <= burst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_chan
      fifo_ctrl_chan #(.CNT_W(CNT_W)) u_chan (
         .i_clk             (i_clk),
         .i_rst             (i_rst),
         .i_run             (run),
         .i_idle            (idle),
         .i_go              (go),
         .i_keep            (keep),
         .i_skew_ok         (skew_ok[k]),
         .i_burst           (burst_q),
         .i_mode            (mode_q),
         .i_fifo_empty      (i_fifo_empty[k]),
         .i_fifo_array_full (i_fifo_array_full[k]),
         .o_rd_en           (o_fifo_read_enable[k]),
         .o_sr_en           (o_sr_enable[k]),
         .o_cnt_done_q      (cnt_done_q[k]),
         .o_cnt_done_d      (cnt_done_d[k])
      );
   end

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_underrun = underrun_q;

endmodule
